// File: rtl/sram_a_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : sram_a_window_reader
// Description : Scans a 28x28 frame held in four group-A SRAM banks as 169
//               overlapping 4x4-pixel windows, behind a 2-entry output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_a_window_reader #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a0,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a1,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a2,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_rdata_a3,
    output logic [5:0]                              sram_raddr_a0,
    output logic [5:0]                              sram_raddr_a1,
    output logic [5:0]                              sram_raddr_a2,
    output logic [5:0]                              sram_raddr_a3,
    input  logic                                    win_ready,
    output logic                                    win_valid,
    output logic [CH_NUM*16*BW_PER_ACT-1:0]         win_data,
    output logic [3:0]                              win_row,
    output logic [3:0]                              win_col,
    output logic                                    busy,
    output logic                                    done
);

    localparam int C_WORD_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
    localparam int C_WIN_W  = CH_NUM * 16 * BW_PER_ACT;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] C_LAST = 4'd12;

    logic [1:0]         state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic               rd_vld_q;
    logic [3:0]         rd_row_q, rd_col_q;
    logic [C_WIN_W-1:0] fifo_data_q [2];
    logic [3:0]         fifo_row_q  [2];
    logic [3:0]         fifo_col_q  [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         count_q;
    logic [5:0]         raddr_q [4];

    logic [5:0]          w_addr [4];
    logic [C_WORD_W-1:0] w_bank [4];
    logic [C_WIN_W-1:0]  w_win;
    logic [1:0]          w_sel;
    logic                w_pop, w_push, w_issue, w_last;

    assign w_bank[0] = sram_rdata_a0;
    assign w_bank[1] = sram_rdata_a1;
    assign w_bank[2] = sram_rdata_a2;
    assign w_bank[3] = sram_rdata_a3;

    assign w_pop  = (count_q != 2'd0) && win_ready;
    assign w_push = rd_vld_q;
    assign w_last = (row_q == C_LAST) && (col_q == C_LAST);

    // A read is safe when the FIFO can still hold it after everything ahead of it lands.
    assign w_issue = (state_q == S_RUN) &&
                     (({1'b0, count_q} + {2'b00, rd_vld_q} - {2'b00, w_pop}) < 3'd2);

    // Bank b holds the window block whose row/col parities match b's bits.
    function automatic logic [5:0] f_bank_addr(input logic [3:0] br, input logic [3:0] bc,
                                               input logic [1:0] bank);
        logic [3:0] r;
        logic [3:0] c;
        r = br + {3'b000, bank[1] ^ br[0]};
        c = bc + {3'b000, bank[0] ^ bc[0]};
        return ({3'b000, r[3:1]} * 6'd7) + {3'b000, c[3:1]};
    endfunction

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_addr[b] = w_issue ? f_bank_addr(row_q, col_q, 2'(b)) : raddr_q[b];
        end
    end

    assign sram_raddr_a0 = w_addr[0];
    assign sram_raddr_a1 = w_addr[1];
    assign sram_raddr_a2 = w_addr[2];
    assign sram_raddr_a3 = w_addr[3];

    always_comb begin
        w_win = '0;
        w_sel = '0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                w_sel = {rd_row_q[0] ^ (y >= 2), rd_col_q[0] ^ (x >= 2)};
                for (int ch = 0; ch < CH_NUM; ch++) begin
                    w_win[(ch*16 + y*4 + x)*BW_PER_ACT +: BW_PER_ACT] =
                        w_bank[w_sel][(ch*ACT_PER_ADDR + 2*(y%2) + (x%2))*BW_PER_ACT +: BW_PER_ACT];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    if (w_last) begin
                        state_d = S_DRAIN;
                    end
                    if (col_q == C_LAST) begin
                        col_d = 4'd0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Done once the last entry leaves this cycle and nothing is still returning.
                if (!rd_vld_q && (count_q == {1'b0, w_pop})) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            row_q    <= 4'd0;
            col_q    <= 4'd0;
            rd_vld_q <= 1'b0;
            rd_row_q <= 4'd0;
            rd_col_q <= 4'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_row_q[i]  <= 4'd0;
                fifo_col_q[i]  <= 4'd0;
            end
            for (int b = 0; b < 4; b++) begin
                raddr_q[b] <= 6'd0;
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rd_vld_q <= w_issue;
            if (w_issue) begin
                rd_row_q <= row_q;
                rd_col_q <= col_q;
            end
            for (int b = 0; b < 4; b++) begin
                raddr_q[b] <= w_addr[b];
            end
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= w_win;
                fifo_row_q[wr_ptr_q]  <= rd_row_q;
                fifo_col_q[wr_ptr_q]  <= rd_col_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign win_valid = (count_q != 2'd0);
    assign win_data  = fifo_data_q[rd_ptr_q];
    assign win_row   = fifo_row_q[rd_ptr_q];
    assign win_col   = fifo_col_q[rd_ptr_q];
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire
